// File: rtl/adder_unit.sv
// adder_unit: registered unsigned a+b, wrap-around or saturating with ADDER_UNIT_SATURATE_EN defined.
// Latency 1 cycle, one result per cycle; no handshake and no backpressure, the register loads every edge.
module adder_unit #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum
);

   logic [WIDTH-1:0] sum_nxt;

`ifdef ADDER_UNIT_SATURATE_EN
   logic [WIDTH:0] full_sum;

   assign full_sum = {1'b0, a} + {1'b0, b};
   // Carry out means the true result does not fit: clamp to all-ones.
   assign sum_nxt  = full_sum[WIDTH] ? {WIDTH{1'b1}} : full_sum[WIDTH-1:0];
`else
   assign sum_nxt  = a + b;
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sum <= '0;
      end else begin
         sum <= sum_nxt;
      end
   end

endmodule

// File: tb/tb_adder_unit.sv
// Directed bench for adder_unit at WIDTH 8, 1 and 16; expectations follow the build's overflow mode.
// Inputs change on the falling edge, outputs are sampled 1 time unit after the rising edge.
module tb_adder_unit;

   logic        clk;
   logic        rstn;
   logic [7:0]  a8, b8, sum8;
   logic [0:0]  a1, b1, sum1;
   logic [15:0] a16, b16, sum16;

   int checks;
   int errors;

   adder_unit #(.WIDTH(8)) dut8 (
      .clk(clk), .rstn(rstn), .a(a8), .b(b8), .sum(sum8)
   );

   adder_unit #(.WIDTH(1)) dut1 (
      .clk(clk), .rstn(rstn), .a(a1), .b(b1), .sum(sum1)
   );

   adder_unit #(.WIDTH(16)) dut16 (
      .clk(clk), .rstn(rstn), .a(a16), .b(b16), .sum(sum16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      // a/b left undriven (X) while reset is held
      rstn = 1'b0;
      #1;
      checks++;
      if (sum8 !== 8'd0 || sum1 !== 1'b0 || sum16 !== 16'd0) begin
         errors++;
         $display("FAIL reset_async: sum8=%h sum1=%h sum16=%h, required all zero", sum8, sum1, sum16);
      end
      @(posedge clk); #1;
      checks++;
      if (sum8 !== 8'd0 || sum1 !== 1'b0 || sum16 !== 16'd0) begin
         errors++;
         $display("FAIL reset_hold_edge: sum8=%h sum1=%h sum16=%h, required all zero", sum8, sum1, sum16);
      end
      @(negedge clk);
      rstn = 1'b1;
      a8 = 8'd0;  b8 = 8'd0;
      a1 = 1'b0;  b1 = 1'b0;
      a16 = 16'd0; b16 = 16'd0;
      #1;
      checks++;
      if (sum8 !== 8'd0) begin
         errors++;
         $display("FAIL reset_release_noedge: sum8=%h, required 00", sum8);
      end
   endtask

   task automatic test_basic();
      logic [7:0] va [3];
      logic [7:0] vb [3];
      logic [7:0] ve [3];
      va = '{8'd0, 8'd15, 8'd25};
      vb = '{8'd0, 8'd10, 8'd30};
      ve = '{8'd0, 8'd25, 8'd55};
      for (int i = 0; i < 3; i++) begin
         if (i != 0) begin
            @(negedge clk);
            a8 = va[i];
            b8 = vb[i];
         end
         @(posedge clk); #1;
         checks++;
         if (sum8 !== ve[i]) begin
            errors++;
            $display("FAIL basic_add[%0d]: sum=%0d, required %0d", i, sum8, ve[i]);
         end
      end
   endtask

   task automatic test_latency();
      @(negedge clk);
      a8 = 8'd15; b8 = 8'd10;
      @(posedge clk); #1;
      checks++;
      if (sum8 !== 8'd25) begin
         errors++;
         $display("FAIL latency_first: sum=%0d, required 25", sum8);
      end
      #2 a8 = 8'd20;
      #1;
      checks++;
      if (sum8 !== 8'd25) begin
         errors++;
         $display("FAIL latency_midcycle_hold: sum=%0d, required 25", sum8);
      end
      @(negedge clk); #1;
      checks++;
      if (sum8 !== 8'd25) begin
         errors++;
         $display("FAIL latency_before_edge: sum=%0d, required 25", sum8);
      end
      @(posedge clk); #1;
      checks++;
      if (sum8 !== 8'd30) begin
         errors++;
         $display("FAIL latency_update: sum=%0d, required 30", sum8);
      end
   endtask

   task automatic test_overflow();
      logic [7:0] va [3];
      logic [7:0] vb [3];
      logic [7:0] ve [3];
      va = '{8'd200, 8'd255, 8'd128};
      vb = '{8'd100, 8'd1,   8'd127};
`ifdef ADDER_UNIT_SATURATE_EN
      ve = '{8'd255, 8'd255, 8'd255};
`else
      ve = '{8'd44,  8'd0,   8'd255};
`endif
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         a8 = va[i];
         b8 = vb[i];
         @(posedge clk); #1;
         checks++;
         if (sum8 !== ve[i]) begin
            errors++;
            $display("FAIL overflow[%0d]: %0d+%0d gave %0d, required %0d", i, va[i], vb[i], sum8, ve[i]);
         end
      end
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      a8 = 8'd25; b8 = 8'd30;
      @(posedge clk); #1;
      checks++;
      if (sum8 !== 8'd55) begin
         errors++;
         $display("FAIL async_pre: sum=%0d, required 55", sum8);
      end
      #2 rstn = 1'b0;
      #1;
      checks++;
      if (sum8 !== 8'd0) begin
         errors++;
         $display("FAIL async_clear: sum=%0d, required 0", sum8);
      end
      a8 = 8'd7; b8 = 8'd9;
      @(posedge clk); #1;
      checks++;
      if (sum8 !== 8'd0) begin
         errors++;
         $display("FAIL async_hold: sum=%0d, required 0", sum8);
      end
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (sum8 !== 8'd16) begin
         errors++;
         $display("FAIL async_after_release: sum=%0d, required 16", sum8);
      end
   endtask

   task automatic test_width1();
      logic [0:0] va [3];
      logic [0:0] vb [3];
      logic [0:0] ve [3];
      va = '{1'b1, 1'b1, 1'b0};
      vb = '{1'b1, 1'b0, 1'b0};
`ifdef ADDER_UNIT_SATURATE_EN
      ve = '{1'b1, 1'b1, 1'b0};
`else
      ve = '{1'b0, 1'b1, 1'b0};
`endif
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         a1 = va[i];
         b1 = vb[i];
         @(posedge clk); #1;
         checks++;
         if (sum1 !== ve[i]) begin
            errors++;
            $display("FAIL width1[%0d]: %0d+%0d gave %0d, required %0d", i, va[i], vb[i], sum1, ve[i]);
         end
      end
   endtask

   task automatic test_width16_sweep();
      logic [16:0] wide;
      logic [15:0] expv;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         a16 = 16'($urandom);
         b16 = 16'($urandom);
         if (i == 0) begin
            a16 = 16'hFFFF; b16 = 16'h0001;
         end
         wide = 17'(a16) + 17'(b16);
`ifdef ADDER_UNIT_SATURATE_EN
         expv = (wide > 17'h0FFFF) ? 16'hFFFF : wide[15:0];
`else
         expv = wide[15:0];
`endif
         @(posedge clk); #1;
         checks++;
         if (sum16 !== expv) begin
            errors++;
            $display("FAIL width16[%0d]: %h+%h gave %h, required %h", i, a16, b16, sum16, expv);
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_basic();
      test_latency();
      test_overflow();
      test_async_reset();
      test_width1();
      test_width16_sweep();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
